// File: rtl/memtrace_cmp.sv
// Order-based equivalence checker for two picorv32 native memory ports.
// Completed transactions from each port are queued and compared pairwise in arrival order.
module memtrace_cmp #(
   parameter int DEPTH     = 8,
   parameter bit CMP_WDATA = 1'b1
) (
   input  logic                       clock,
   input  logic                       resetn,
   input  logic                       mem_valid_a,
   input  logic                       mem_ready_a,
   input  logic                       mem_instr_a,
   input  logic [31:0]                mem_addr_a,
   input  logic [31:0]                mem_wdata_a,
   input  logic [3:0]                 mem_wstrb_a,
   input  logic                       mem_valid_b,
   input  logic                       mem_ready_b,
   input  logic                       mem_instr_b,
   input  logic [31:0]                mem_addr_b,
   input  logic [31:0]                mem_wdata_b,
   input  logic [3:0]                 mem_wstrb_b,
   output logic                       mismatch,
   output logic                       overflow,
   output logic [31:0]                match_cnt,
   output logic [31:0]                first_addr_a,
   output logic [31:0]                first_addr_b,
   output logic [31:0]                first_idx,
   output logic [$clog2(DEPTH):0]     level_a,
   output logic [$clog2(DEPTH):0]     level_b
);

   localparam int AW      = $clog2(DEPTH);
   localparam int LW      = AW + 1;
   localparam int ENTRY_W = 69;
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

   // Entry layout: {instr, addr[31:0], wstrb[3:0], wdata[31:0]}
   function automatic logic entries_equal(input logic [ENTRY_W-1:0] ea,
                                          input logic [ENTRY_W-1:0] eb);
      logic same_ctl;
      logic need_wdata;
      same_ctl   = (ea[68:32] == eb[68:32]);
      need_wdata = CMP_WDATA && (ea[35:32] != 4'h0);
      return same_ctl && (!need_wdata || (ea[31:0] == eb[31:0]));
   endfunction

   logic [ENTRY_W-1:0] fifo_a_r [DEPTH];
   logic [ENTRY_W-1:0] fifo_b_r [DEPTH];
   logic [AW-1:0]      wr_a_r, rd_a_r, wr_b_r, rd_b_r;
   logic [LW-1:0]      level_a_r, level_b_r;
   logic               mismatch_r, overflow_r;
   logic [31:0]        match_cnt_r, first_addr_a_r, first_addr_b_r, first_idx_r;

   logic [ENTRY_W-1:0] entry_a_s, entry_b_s, head_a_s, head_b_s;
   logic               push_a_s, push_b_s, acc_a_s, acc_b_s, drop_a_s, drop_b_s;
   logic               pop_s, pair_eq_s;

   // Capture qualification, full handling and pair comparison
   always_comb begin
      entry_a_s = {mem_instr_a, mem_addr_a, mem_wstrb_a, mem_wdata_a};
      entry_b_s = {mem_instr_b, mem_addr_b, mem_wstrb_b, mem_wdata_b};
      push_a_s  = mem_valid_a && mem_ready_a;
      push_b_s  = mem_valid_b && mem_ready_b;
      pop_s     = (level_a_r != {LW{1'b0}}) && (level_b_r != {LW{1'b0}});
      // A full FIFO can still take a push when its head leaves on the same edge
      acc_a_s   = push_a_s && ((level_a_r != FULL_LVL) || pop_s);
      acc_b_s   = push_b_s && ((level_b_r != FULL_LVL) || pop_s);
      drop_a_s  = push_a_s && !acc_a_s;
      drop_b_s  = push_b_s && !acc_b_s;
      head_a_s  = fifo_a_r[rd_a_r];
      head_b_s  = fifo_b_r[rd_b_r];
      pair_eq_s = entries_equal(head_a_s, head_b_s);
   end

   // FIFO storage; contents need no reset since level gates visibility
   always_ff @(posedge clock) begin
      if (resetn && acc_a_s) begin
         fifo_a_r[wr_a_r] <= entry_a_s;
      end
      if (resetn && acc_b_s) begin
         fifo_b_r[wr_b_r] <= entry_b_s;
      end
   end

   // Pointer and occupancy bookkeeping for both FIFOs
   always_ff @(posedge clock) begin
      if (!resetn) begin
         wr_a_r    <= {AW{1'b0}};
         rd_a_r    <= {AW{1'b0}};
         wr_b_r    <= {AW{1'b0}};
         rd_b_r    <= {AW{1'b0}};
         level_a_r <= {LW{1'b0}};
         level_b_r <= {LW{1'b0}};
      end else begin
         if (acc_a_s) wr_a_r <= wr_a_r + {{(AW-1){1'b0}}, 1'b1};
         if (acc_b_s) wr_b_r <= wr_b_r + {{(AW-1){1'b0}}, 1'b1};
         if (pop_s) begin
            rd_a_r <= rd_a_r + {{(AW-1){1'b0}}, 1'b1};
            rd_b_r <= rd_b_r + {{(AW-1){1'b0}}, 1'b1};
         end
         case ({acc_a_s, pop_s})
            2'b10:   level_a_r <= level_a_r + {{(LW-1){1'b0}}, 1'b1};
            2'b01:   level_a_r <= level_a_r - {{(LW-1){1'b0}}, 1'b1};
            default: level_a_r <= level_a_r;
         endcase
         case ({acc_b_s, pop_s})
            2'b10:   level_b_r <= level_b_r + {{(LW-1){1'b0}}, 1'b1};
            2'b01:   level_b_r <= level_b_r - {{(LW-1){1'b0}}, 1'b1};
            default: level_b_r <= level_b_r;
         endcase
      end
   end

   // Sticky result flags, match counter and first-mismatch diagnostics
   always_ff @(posedge clock) begin
      if (!resetn) begin
         mismatch_r     <= 1'b0;
         overflow_r     <= 1'b0;
         match_cnt_r    <= 32'h0;
         first_addr_a_r <= 32'h0;
         first_addr_b_r <= 32'h0;
         first_idx_r    <= 32'h0;
      end else begin
         if (drop_a_s || drop_b_s) overflow_r <= 1'b1;
         if (pop_s && pair_eq_s) begin
            if (match_cnt_r != 32'hFFFF_FFFF) match_cnt_r <= match_cnt_r + 32'h1;
         end else if (pop_s) begin
            mismatch_r <= 1'b1;
            if (!mismatch_r) begin
               first_addr_a_r <= head_a_s[67:36];
               first_addr_b_r <= head_b_s[67:36];
               first_idx_r    <= match_cnt_r;
            end
         end
      end
   end

   assign mismatch     = mismatch_r;
   assign overflow     = overflow_r;
   assign match_cnt    = match_cnt_r;
   assign first_addr_a = first_addr_a_r;
   assign first_addr_b = first_addr_b_r;
   assign first_idx    = first_idx_r;
   assign level_a      = level_a_r;
   assign level_b      = level_b_r;

endmodule
